// File: rtl/alu_share_pkg.sv
// Shared types, opcode layout and behavioural result function for the
// alu_share_arbiter slice.
package alu_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    localparam int unsigned OP_S1  = 2;
    localparam int unsigned OP_S0  = 1;
    localparam int unsigned OP_CIN = 0;

    localparam logic [1:0] SEL_B    = 2'b00;
    localparam logic [1:0] SEL_NB   = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;
    localparam logic [1:0] SEL_ONES = 2'b11;

    // (A + Y + Cin) mod 2^(w+1), Y chosen by {S1,S0}
    function automatic logic [31:0] exp_result(
        input int unsigned w,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  op
    );
        logic [31:0] mask;
        logic [31:0] y;
        mask = (32'd1 << w) - 32'd1;
        case ({op[OP_S1], op[OP_S0]})
            SEL_B:    y = b & mask;
            SEL_NB:   y = ~b & mask;
            SEL_ZERO: y = '0;
            default:  y = mask;
        endcase
        return ((a & mask) + y + 32'(op[OP_CIN])) & ((mask << 1) | 32'd1);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: request pair plus last-granted index gives a
// one-hot grant.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external add/subtract datapath between two requesters.
// Optional capture-time result checking: define ALU_SHARE_CHECK_EN.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned W             = 4,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req0,
    input  logic         req1,
    input  logic [2:0]   op0,
    input  logic [2:0]   op1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W:0]   res0,
    output logic [W:0]   res1,
    output logic [W-1:0] dp_A,
    output logic [W-1:0] dp_B,
    output logic         dp_S1,
    output logic         dp_S0,
    output logic         dp_Cin,
    input  logic [W-1:0] dp_D,
    input  logic         dp_Cout,
    output logic         busy,
    output logic         err
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t       r_state, w_state;
    logic [3:0]   r_cnt, w_cnt;
    logic [1:0]   r_gnt, w_gnt;
    logic [1:0]   r_done, w_done;
    logic         r_last, w_last;
    logic [W-1:0] r_dpA, w_dpA;
    logic [W-1:0] r_dpB, w_dpB;
    logic [2:0]   r_dpop, w_dpop;
    logic [W:0]   r_cap, w_cap;
    logic [W:0]   r_res0, w_res0;
    logic [W:0]   r_res1, w_res1;
    logic         w_capture;
    logic [1:0]   w_arb;

    rr_arb2 u_arb (
        .i_req  ({req1, req0}),
        .i_last (r_last),
        .o_gnt  (w_arb)
    );

    // r_last doubles as the index of the requester currently being served
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_gnt     = '0;
        w_done    = '0;
        w_last    = r_last;
        w_dpA     = r_dpA;
        w_dpB     = r_dpB;
        w_dpop    = r_dpop;
        w_cap     = r_cap;
        w_res0    = r_res0;
        w_res1    = r_res1;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_arb) begin
                    w_last  = w_arb[1];
                    w_gnt   = w_arb;
                    w_dpA   = w_arb[1] ? a1 : a0;
                    w_dpB   = w_arb[1] ? b1 : b0;
                    w_dpop  = w_arb[1] ? op1 : op0;
                    w_cnt   = CNT_LOAD;
                    w_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - 4'd1;
                end else begin
                    w_cap     = {dp_Cout, dp_D};
                    w_capture = 1'b1;
                    w_state   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (r_last) begin
                    w_res1 = r_cap;
                    w_done = 2'b10;
                end else begin
                    w_res0 = r_cap;
                    w_done = 2'b01;
                end
                w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(negedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_last  <= 1'b1;
            r_dpA   <= '0;
            r_dpB   <= '0;
            r_dpop  <= '0;
            r_cap   <= '0;
            r_res0  <= '0;
            r_res1  <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_gnt   <= w_gnt;
            r_done  <= w_done;
            r_last  <= w_last;
            r_dpA   <= w_dpA;
            r_dpB   <= w_dpB;
            r_dpop  <= w_dpop;
            r_cap   <= w_cap;
            r_res0  <= w_res0;
            r_res1  <= w_res1;
        end
    end

    assign gnt0   = r_gnt[0];
    assign gnt1   = r_gnt[1];
    assign done0  = r_done[0];
    assign done1  = r_done[1];
    assign res0   = r_res0;
    assign res1   = r_res1;
    assign dp_A   = r_dpA;
    assign dp_B   = r_dpB;
    assign dp_S1  = r_dpop[OP_S1];
    assign dp_S0  = r_dpop[OP_S0];
    assign dp_Cin = r_dpop[OP_CIN];
    assign busy   = (r_state != ST_IDLE);

`ifdef ALU_SHARE_CHECK_EN
    logic r_err;

    always_ff @(negedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_capture &&
                     (32'(w_cap) != exp_result(W, 32'(r_dpA), 32'(r_dpB), r_dpop))) begin
            r_err <= 1'b1;
            $display("ERROR!");
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural datapath and
// a plain-arithmetic result model.
module tb_alu_share_arbiter;

    localparam int unsigned S = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] op0 = '0, op1 = '0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       gnt0, gnt1, done0, done1;
    logic [4:0] res0, res1;
    logic [3:0] dp_A, dp_B, dp_D;
    logic       dp_S1, dp_S0, dp_Cin, dp_Cout;
    logic       busy, err;
    logic       inject = 1'b0;
    logic [4:0] dp_res;

    int n_vec = 0;
    int n_err = 0;

    alu_share_arbiter #(.W(4), .SETTLE_CYCLES(S)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1),
        .dp_A(dp_A), .dp_B(dp_B), .dp_S1(dp_S1), .dp_S0(dp_S0), .dp_Cin(dp_Cin),
        .dp_D(dp_D), .dp_Cout(dp_Cout), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    // Behavioural shared datapath; inject forces D off by one
    assign dp_res  = 5'(alu_share_pkg::exp_result(4, {28'd0, dp_A}, {28'd0, dp_B},
                                                  {dp_S1, dp_S0, dp_Cin}));
    assign dp_D    = dp_res[3:0] + {3'd0, inject};
    assign dp_Cout = dp_res[4];

    function automatic logic [4:0] model(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        int unsigned y;
        int unsigned r;
        case (op[2:1])
            2'd0:    y = b;
            2'd1:    y = 15 - b;
            2'd2:    y = 0;
            default: y = 15;
        endcase
        r = (a + y + op[0]) % 32;
        return r[4:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {gnt0, gnt1, done0, done1, busy, dp_S1, dp_S0, dp_Cin,
                    res0, res1, dp_A, dp_B}, 32'd0);
    endtask

    task automatic serve(input int who, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [4:0] exp_res);
        int n;
        int lat;
        logic g, d;
        @(posedge CLK);
        if (who == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else          begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        n = 0;
        do begin
            @(posedge CLK); n++;
            g = (who == 0) ? gnt0 : gnt1;
        end while (!g && n < 30);
        check("gnt", g, 1);
        check("gnt_latency", n, 1);
        check("gnt_other", (who == 0) ? gnt1 : gnt0, 0);
        check("dp_latch", {dp_A, dp_B, dp_S1, dp_S0, dp_Cin}, {a, b, op});
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        lat = 0;
        do begin
            @(posedge CLK); lat++;
            d = (who == 0) ? done0 : done1;
            if (lat == 1) check("gnt_pulse", (who == 0) ? gnt0 : gnt1, 0);
            if (lat == S) check("dp_hold", {dp_A, dp_B, dp_S1, dp_S0, dp_Cin}, {a, b, op});
        end while (!d && lat < 30);
        check("done_latency", lat, S + 1);
        check("done_other", (who == 0) ? done1 : done0, 0);
        check("res", (who == 0) ? res0 : res1, exp_res);
        check("idle_at_done", busy, 0);
    endtask

    initial begin : main
        logic [4:0] q0[$];
        logic [4:0] q1[$];
        logic [4:0] pop;
        logic [2:0] rop;
        logic [3:0] ra, rb;
        int         who, t, ngr, last_t, exp_who, seen_done;
        logic       pbusy;

        // Reset state
        repeat (3) @(posedge CLK);
        RST = 1'b0;
        check_all_zero("reset_outputs");
        check("reset_err", err, 0);

        // Directed datapath cases
        serve(0, 3'b000, 4'd5, 4'd3, 5'h08);
        serve(1, 3'b011, 4'd5, 4'd3, 5'b10010);
        check("res0_held", res0, 5'h08);
        serve(0, 3'b110, 4'd0, 4'd9, 5'h0F);
        serve(1, 3'b100, 4'd15, 4'd2, 5'h0F);
        serve(0, 3'b001, 4'd15, 4'd15, 5'h1F);

        // Randomized single-requester transactions
        for (int i = 0; i < 16; i++) begin
            who = int'($urandom_range(0, 1));
            rop = 3'($urandom);
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            serve(who, rop, ra, rb, model(rop, ra, rb));
        end

        // Reset mid-operation, after a req0 grant so the pointer would favour req1
        serve(0, 3'b000, 4'd1, 4'd1, 5'h02);
        @(posedge CLK);
        req0 = 1'b1; op0 = 3'b000; a0 = 4'd7; b0 = 4'd7;
        t = 0;
        do begin @(posedge CLK); t++; end while (!gnt0 && t < 30);
        check("mid_gnt", gnt0, 1);
        req0 = 1'b0;
        @(posedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        RST = 1'b0;
        check_all_zero("mid_reset_outputs");
        seen_done = 0;
        repeat (S + 4) begin
            @(posedge CLK);
            if (done0 || done1) seen_done++;
        end
        check("mid_no_done", seen_done, 0);

        // Tie: both requesters held high, fresh random operands after each grant
        @(posedge CLK);
        op0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
        op1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        exp_who = 0; ngr = 0; t = 0; last_t = 0; pbusy = busy;
        while ((ngr < 6 || q0.size() + q1.size() != 0) && t < 300) begin
            @(posedge CLK); t++;
            if (gnt0 || gnt1) begin
                check("tie_onehot", {gnt0, gnt1}, gnt0 ? 32'd2 : 32'd1);
                check("tie_who", gnt1, exp_who);
                check("tie_not_busy_before", pbusy, 0);
                if (ngr > 0) check("tie_interval", t - last_t, S + 2);
                last_t = t;
                ngr++;
                if (gnt0) begin
                    q0.push_back(model(op0, a0, b0));
                    op0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
                    if (ngr >= 5) req0 = 1'b0;
                end else begin
                    q1.push_back(model(op1, a1, b1));
                    op1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
                    if (ngr >= 5) req1 = 1'b0;
                end
                exp_who = 1 - exp_who;
            end
            if (done0) begin
                check("tie_done0_expected", q0.size() != 0, 1);
                if (q0.size() != 0) begin pop = q0.pop_front(); check("tie_res0", res0, pop); end
            end
            if (done1) begin
                check("tie_done1_expected", q1.size() != 0, 1);
                if (q1.size() != 0) begin pop = q1.pop_front(); check("tie_res1", res1, pop); end
            end
            pbusy = busy;
        end
        check("tie_grants", ngr, 6);
        check("tie_drained", q0.size() + q1.size(), 0);
        req0 = 1'b0; req1 = 1'b0;

        // Corrupted datapath result
        inject = 1'b1;
        serve(0, 3'b000, 4'd5, 4'd3, 5'h09);
        inject = 1'b0;
`ifdef ALU_SHARE_CHECK_EN
        check("err_set", err, 1);
        serve(1, 3'b000, 4'd2, 4'd2, 5'h04);
        check("err_sticky", err, 1);
        @(posedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        RST = 1'b0;
        check("err_cleared", err, 0);
`else
        check("err_off", err, 0);
        serve(1, 3'b000, 4'd2, 4'd2, 5'h04);
        check("err_off_after", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
